// File: rtl/led_pkg.sv
// ============================================================================
// Module : led_pkg
// Brief  : Shared types, GRB colour constants and sequencer state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package led_pkg;

    typedef logic [23:0] rgb_t;

    // WS2812B words are ordered G[23:16] R[15:8] B[7:0]
    localparam rgb_t LED_OFF   = 24'h000000;
    localparam rgb_t LED_GREEN = 24'hff0000;
    localparam rgb_t LED_RED   = 24'h00ff00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic rgb_t pick_colour(input logic on, input rgb_t on_c, input rgb_t off_c);
        return on ? on_c : off_c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_chain_sequencer_refresh_timer.sv
// ============================================================================
// Module : refresh_timer
// Brief  : Free-running period counter giving a one-cycle tick per refresh.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module refresh_timer #(
    parameter int CLK_FREQ   = 27_000_000,
    parameter int REFRESH_HZ = 30
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    generate
        if (REFRESH_HZ == 0) begin : g_no_timer
            assign tick = 1'b0;
        end else begin : g_timer
            localparam int PERIOD = CLK_FREQ / REFRESH_HZ;
            localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
            localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

            logic [TW-1:0] count;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    count <= '0;
                end else if (count == LAST) begin
                    count <= '0;
                end else begin
                    count <= count + TW'(1);
                end
            end

            assign tick = (count == LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/led_chain_sequencer.sv
// ============================================================================
// Module : led_chain_sequencer
// Brief  : Frame controller feeding one GRB word per LED to led_driver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module led_chain_sequencer
    import led_pkg::*;
#(
    parameter int   CLK_FREQ   = 27_000_000,
    parameter int   NUM_LEDS   = 16,
    parameter rgb_t ON_COLOR   = LED_RED,
    parameter rgb_t OFF_COLOR  = LED_OFF,
    parameter int   REFRESH_HZ = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEDS-1:0] led_state,
    input  logic                frame_req,
    output logic                frame_active,
    output logic                frame_done,
    output logic                drv_ready,
    output rgb_t                drv_rgb,
    input  logic                drv_busy,
    input  logic                drv_data_latched
);

    localparam int IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);

    seq_state_t          state;
    seq_state_t          state_nx;
    logic [IW-1:0]       idx;
    logic [NUM_LEDS-1:0] snap;
    logic                pending;
    logic                tick;
    logic                trigger;
    logic                ready_d;
    logic                active_d;
    logic                done_d;
    rgb_t                rgb_d;

    refresh_timer #(
        .CLK_FREQ   (CLK_FREQ),
        .REFRESH_HZ (REFRESH_HZ)
    ) u_refresh_timer (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign trigger = frame_req | pending | tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            snap         <= '0;
            pending      <= 1'b0;
            drv_ready    <= 1'b0;
            drv_rgb      <= OFF_COLOR;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                pending <= 1'b0;
                if (trigger) begin
                    snap <= led_state;
                    idx  <= '0;
                end
            end else if (frame_req || tick) begin
                pending <= 1'b1;
            end
            if (state == SEND && drv_data_latched && idx != LAST_IDX) begin
                idx <= idx + IW'(1);
            end
            drv_ready    <= ready_d;
            drv_rgb      <= rgb_d;
            frame_active <= active_d;
            frame_done   <= done_d;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (trigger) state_nx = SEND;
            SEND:    if (drv_data_latched && idx == LAST_IDX) state_nx = DRAIN;
            DRAIN:   if (!drv_busy) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs follow the current state one edge later so every port is a flop
    always_comb begin
        ready_d  = (state == SEND);
        active_d = (state == SEND) || (state == DRAIN);
        done_d   = (state == DONE);
        rgb_d    = pick_colour(snap[idx], ON_COLOR, OFF_COLOR);
    end

endmodule

`default_nettype wire

// File: tb/tb_led_chain_sequencer.sv
// ============================================================================
// Module : tb_led_chain_sequencer
// Brief  : Self-checking bench with driver models for a 4-LED and a 1-LED chain.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_led_chain_sequencer;

    localparam logic [23:0] ON_C  = 24'h00ff00;
    localparam logic [23:0] OFF_C = 24'h000000;
    localparam int          N     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, frame_req, frame_active, frame_done, drv_ready, drv_busy, lat_m, stray;
    logic [N-1:0] led_state;
    logic [23:0]  drv_rgb;
    logic         rst1, req1, act1, done1, rdy1, busy1, lat1_m, stray1;
    logic [0:0]   led1;
    logic [23:0]  rgb1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [23:0] lat_q[$], exp_q[$], lat1_q[$];
    int          rise_q[$], done_q[$], rise1_q[$], done1_q[$];
    int          last_lat_cyc = 0, ready_fall_cyc = 0;
    logic        act_prev = 1'b0, rdy_prev = 1'b0, act1_prev = 1'b0;

    led_chain_sequencer #(
        .CLK_FREQ(27_000_000), .NUM_LEDS(N), .ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .REFRESH_HZ(0)
    ) dut (
        .clk(clk), .rst(rst), .led_state(led_state), .frame_req(frame_req),
        .frame_active(frame_active), .frame_done(frame_done), .drv_ready(drv_ready),
        .drv_rgb(drv_rgb), .drv_busy(drv_busy), .drv_data_latched(lat_m | stray)
    );

    led_chain_sequencer #(
        .CLK_FREQ(2_000_000), .NUM_LEDS(1), .ON_COLOR(ON_C), .OFF_COLOR(OFF_C), .REFRESH_HZ(1000)
    ) dut1 (
        .clk(clk), .rst(rst1), .led_state(led1), .frame_req(req1),
        .frame_active(act1), .frame_done(done1), .drv_ready(rdy1),
        .drv_rgb(rgb1), .drv_busy(busy1), .drv_data_latched(lat1_m | stray1)
    );

    // Driver model: first latch 40 cycles after ready, then every 40; when ready
    // is gone at a pixel boundary it finishes and holds busy for a 100-cycle gap.
    int cnt, cnt1;
    logic gap, gap1;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            drv_busy <= 1'b0; lat_m <= 1'b0; gap <= 1'b0; cnt <= 0;
        end else begin
            lat_m <= 1'b0;
            if (!drv_busy) begin
                if (drv_ready) begin drv_busy <= 1'b1; cnt <= 1; gap <= 1'b0; end
            end else if (gap) begin
                if (cnt == 100) drv_busy <= 1'b0; else cnt <= cnt + 1;
            end else if (cnt == 40) begin
                cnt <= 1;
                if (drv_ready) lat_m <= 1'b1; else gap <= 1'b1;
            end else cnt <= cnt + 1;
        end
    end

    always @(posedge clk or negedge rst1) begin
        if (!rst1) begin
            busy1 <= 1'b0; lat1_m <= 1'b0; gap1 <= 1'b0; cnt1 <= 0;
        end else begin
            lat1_m <= 1'b0;
            if (!busy1) begin
                if (rdy1) begin busy1 <= 1'b1; cnt1 <= 1; gap1 <= 1'b0; end
            end else if (gap1) begin
                if (cnt1 == 100) busy1 <= 1'b0; else cnt1 <= cnt1 + 1;
            end else if (cnt1 == 40) begin
                cnt1 <= 1;
                if (rdy1) lat1_m <= 1'b1; else gap1 <= 1'b1;
            end else cnt1 <= cnt1 + 1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (lat_m) begin lat_q.push_back(drv_rgb); last_lat_cyc = cyc; end
        if (rdy_prev && !drv_ready) ready_fall_cyc = cyc;
        if (frame_active && !act_prev) rise_q.push_back(cyc);
        if (frame_done) done_q.push_back(cyc);
        act_prev = frame_active;
        rdy_prev = drv_ready;
        if (lat1_m) lat1_q.push_back(rgb1);
        if (act1 && !act1_prev) rise1_q.push_back(cyc);
        if (done1) done1_q.push_back(cyc);
        act1_prev = act1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic pulse_req();
        frame_req = 1'b1; step(1); frame_req = 1'b0;
    endtask

    task automatic clear_obs();
        lat_q.delete(); exp_q.delete(); rise_q.delete(); done_q.delete();
    endtask

    // Reference: LED i receives ON_C iff bit i of the snapshot is set, bit 0 first
    task automatic expect_frame(input logic [N-1:0] pat);
        for (int i = 0; i < N; i++) exp_q.push_back(pat[i] ? ON_C : OFF_C);
    endtask

    task automatic compare_latches(input string tag);
        chk({tag, "_count"}, lat_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < lat_q.size(); i++)
            chk($sformatf("%s_px%0d", tag, i), lat_q[i], exp_q[i]);
    endtask

    task automatic wait_done(input int target);
        int b = 0;
        while (done_q.size() < target && b < 4000) begin step(1); b++; end
        chk("done_wait", done_q.size(), target);
    endtask

    task automatic wait_latches(input int target);
        int b = 0;
        while (lat_q.size() < target && b < 2000) begin step(1); b++; end
        chk("latch_wait", lat_q.size(), target);
    endtask

    task automatic wait_rise1(input int target);
        int b = 0;
        while (rise1_q.size() < target && b < 9000) begin step(1); b++; end
        chk("rise1_wait", rise1_q.size(), target);
    endtask

    initial begin
        logic [N-1:0] pa, pb;
        int base, base2, b;

        rst = 1'b0; rst1 = 1'b0; frame_req = 1'b0; req1 = 1'b0;
        led_state = '0; led1 = 1'b1; stray = 1'b0; stray1 = 1'b0;
        step(3);
        chk("rst_ready", drv_ready, 0);
        chk("rst_rgb", drv_rgb, OFF_C);
        chk("rst_active", frame_active, 0);
        chk("rst_done", frame_done, 0);
        rst = 1'b1;
        step(3);

        stray = 1'b1; step(1); stray = 1'b0; step(5);
        chk("stray_idle_active", frame_active, 0);

        // Basic frame and two-edge start latency
        clear_obs();
        led_state = 4'b0101;
        pulse_req();
        chk("lat_ready_early", drv_ready, 0);
        step(1);
        chk("lat_ready", drv_ready, 1);
        chk("lat_active", frame_active, 1);
        chk("first_rgb", drv_rgb, ON_C);
        wait_done(1);
        step(50);
        expect_frame(4'b0101);
        compare_latches("basic");
        // Latch visible in cycle c, DRAIN from c+1, ready low from c+2
        chk("ready_fall", ready_fall_cyc - last_lat_cyc, 2);
        chk("basic_frames", rise_q.size(), 1);
        chk("basic_done_count", done_q.size(), 1);

        // Snapshot holds through a mid-frame led_state change
        clear_obs();
        led_state = 4'b0101;
        pulse_req();
        wait_latches(1);
        led_state = 4'b1111;
        wait_done(1);
        step(5);
        pulse_req();
        wait_done(2);
        expect_frame(4'b0101);
        expect_frame(4'b1111);
        compare_latches("snapshot");

        // Coalescing: three requests during SEND yield exactly one extra frame
        clear_obs();
        pa = N'($urandom); pb = N'($urandom);
        led_state = pa;
        pulse_req();
        wait_latches(1);
        led_state = pb;
        for (int k = 0; k < 3; k++) begin pulse_req(); step(4); end
        wait_done(2);
        step(400);
        chk("coal_frames", rise_q.size(), 2);
        chk("coal_done_count", done_q.size(), 2);
        if (rise_q.size() > 1 && done_q.size() > 0)
            chk("coal_restart_gap", rise_q[1] - done_q[0], 2);
        expect_frame(pa);
        expect_frame(pb);
        compare_latches("coal");

        // Asynchronous reset mid-frame discards the pending frame
        clear_obs();
        led_state = N'($urandom) | 4'b0100;
        pulse_req();
        wait_latches(2);
        pulse_req();
        step(1);
        chk("pre_rst_rgb", drv_rgb, ON_C);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", drv_ready, 0);
        chk("mid_rst_rgb", drv_rgb, OFF_C);
        chk("mid_rst_active", frame_active, 0);
        chk("mid_rst_done", frame_done, 0);
        step(2);
        rst = 1'b1;
        clear_obs();
        step(600);
        chk("post_rst_no_frame", rise_q.size(), 0);

        // Random frames with led_state disturbed mid-frame
        for (int it = 0; it < 5; it++) begin
            clear_obs();
            pa = N'($urandom);
            led_state = pa;
            pulse_req();
            wait_latches(1 + int'($urandom_range(0, 2)));
            led_state = N'($urandom);
            wait_done(1);
            step(20);
            expect_frame(pa);
            compare_latches($sformatf("rand%0d", it));
            chk("rand_frames", rise_q.size(), 1);
        end

        // Single-LED chain with a 2000-cycle auto refresh
        rst1 = 1'b1;
        wait_rise1(3);
        if (rise1_q.size() >= 3) begin
            chk("auto_period0", rise1_q[1] - rise1_q[0], 2000);
            chk("auto_period1", rise1_q[2] - rise1_q[1], 2000);
        end
        b = 0;
        while (done1_q.size() < 3 && b < 1000) begin step(1); b++; end
        chk("auto_done3", done1_q.size(), 3);
        stray1 = 1'b1; step(1); stray1 = 1'b0; step(3);
        chk("stray1_idle_active", act1, 0);

        // Manual frame 50 cycles before a tick: the tick frame follows frame_done
        base = (rise1_q.size() >= 3) ? rise1_q[2] : cyc;
        b = 0;
        while (cyc < base + 1950 && b < 3000) begin step(1); b++; end
        req1 = 1'b1; step(1); req1 = 1'b0;
        wait_rise1(6);
        if (rise1_q.size() >= 6 && done1_q.size() >= 4) begin
            chk("tick_mid_manual", rise1_q[3], base + 1952);
            chk("tick_mid_followup", rise1_q[4] - done1_q[3], 2);
            chk("tick_grid", rise1_q[5], base + 4000);
        end

        // Request coinciding with a tick starts one frame only
        base2 = (rise1_q.size() >= 6) ? rise1_q[5] : cyc;
        b = 0;
        while (cyc < base2 + 1998 && b < 3000) begin step(1); b++; end
        req1 = 1'b1; step(1); req1 = 1'b0;
        wait_rise1(8);
        if (rise1_q.size() >= 8) begin
            chk("coincide_start", rise1_q[6], base2 + 2000);
            chk("coincide_single", rise1_q[7], base2 + 4000);
        end
        b = 0;
        while (done1_q.size() < 8 && b < 1000) begin step(1); b++; end
        chk("n1_latch_count", lat1_q.size(), done1_q.size());
        for (int i = 0; i < lat1_q.size(); i++)
            chk($sformatf("n1_px%0d", i), lat1_q[i], ON_C);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
